// File: rtl/kernel_nios2_div_pkg.sv
// Shared types and constants for the Nios II A-stage iterative divider.
// The signed path is built only when KERNEL_NIOS2_DIV_SIGNED_EN is defined.
package kernel_nios2_div_pkg;

    localparam int DIV_W       = 32;
    localparam int DIV_CNT_W   = 5;
    localparam int DIV_LATENCY = 34;

    localparam logic [DIV_W-1:0] DIV_DZ_QUOT = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_ONE     = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    function automatic logic [DIV_W-1:0] div_neg(input logic [DIV_W-1:0] v);
        return ~v + DIV_ONE;
    endfunction

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] v);
        return v[DIV_W-1] ? div_neg(v) : v;
    endfunction

endpackage

// File: rtl/kernel_nios2_div_cell_if.sv
// Start/operand/result bundle between the A-stage pipeline and the divider.
interface kernel_nios2_div_cell_if #(parameter int DATA_W = 32);

    logic              A_div_start;
    logic [DATA_W-1:0] A_div_src1;
    logic [DATA_W-1:0] A_div_src2;
    logic              A_div_signed;
    logic              A_div_busy;
    logic              A_div_done;
    logic [DATA_W-1:0] A_div_quot;
    logic [DATA_W-1:0] A_div_rem;

    modport master (
        output A_div_start, A_div_src1, A_div_src2, A_div_signed,
        input  A_div_busy, A_div_done, A_div_quot, A_div_rem
    );

    modport slave (
        input  A_div_start, A_div_src1, A_div_src2, A_div_signed,
        output A_div_busy, A_div_done, A_div_quot, A_div_rem
    );

endinterface

// File: rtl/kernel_nios2_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module kernel_nios2_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quot,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quot_next
);

    logic [DATA_W:0] partial_s;

    // Compare is one bit wider than the data so a remainder with its top bit set is not lost.
    always_comb begin
        partial_s = {rem, quot[DATA_W-1]};
        quot_next = {quot[DATA_W-2:0], 1'b0};
        if (partial_s >= {1'b0, divisor}) begin
            rem_next     = partial_s[DATA_W-1:0] - divisor;
            quot_next[0] = 1'b1;
        end else begin
            rem_next     = partial_s[DATA_W-1:0];
            quot_next[0] = 1'b0;
        end
    end

endmodule

// File: rtl/kernel_nios2_div_cell.sv
// Iterative 32-bit restoring divider, fixed 34-cycle latency, registered outputs.
// Define KERNEL_NIOS2_DIV_SIGNED_EN to honour A_div_signed; otherwise all divisions are unsigned.
module kernel_nios2_div_cell
    import kernel_nios2_div_pkg::*;
#(
    parameter int DATA_W = DIV_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    kernel_nios2_div_cell_if.slave   bus
);

    div_state_e        state_r, state_next_s;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] rem_r, quot_r, divisor_r, dividend_r;
    logic              dz_r;
    logic [DATA_W-1:0] rem_step_s, quot_step_s;
    logic [DATA_W-1:0] src1_mag_s, src2_mag_s;
    logic [DATA_W-1:0] quot_fix_s, rem_fix_s;
    logic              busy_r, done_r;
    logic [DATA_W-1:0] quot_out_r, rem_out_r;
    logic              start_s;
`ifdef KERNEL_NIOS2_DIV_SIGNED_EN
    logic              qneg_r, rneg_r;
`endif

    kernel_nios2_div_step #(.DATA_W(DATA_W)) u_step (
        .rem       (rem_r),
        .quot      (quot_r),
        .divisor   (divisor_r),
        .rem_next  (rem_step_s),
        .quot_next (quot_step_s)
    );

    // Operand magnitudes and start qualification.
    always_comb begin
        start_s = bus.A_div_start & (state_r == IDLE);
`ifdef KERNEL_NIOS2_DIV_SIGNED_EN
        if (bus.A_div_signed) begin
            src1_mag_s = div_abs(bus.A_div_src1);
            src2_mag_s = div_abs(bus.A_div_src2);
        end else begin
            src1_mag_s = bus.A_div_src1;
            src2_mag_s = bus.A_div_src2;
        end
`else
        src1_mag_s = bus.A_div_src1;
        src2_mag_s = bus.A_div_src2;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = start_s ? CALC : IDLE;
            CALC:    state_next_s = (count_r == {CNT_W{1'b0}}) ? FIX : CALC;
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Result correction applied in FIX; divide-by-zero wins over sign fix-up.
    always_comb begin
        quot_fix_s = quot_r;
        rem_fix_s  = rem_r;
        if (dz_r) begin
            quot_fix_s = DIV_DZ_QUOT;
            rem_fix_s  = dividend_r;
        end else begin
`ifdef KERNEL_NIOS2_DIV_SIGNED_EN
            quot_fix_s = qneg_r ? div_neg(quot_r) : quot_r;
            rem_fix_s  = rneg_r ? div_neg(rem_r)  : rem_r;
`else
            quot_fix_s = quot_r;
            rem_fix_s  = rem_r;
`endif
        end
    end

    // Iteration datapath: operand capture in IDLE, one step per CALC cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r    <= {CNT_W{1'b0}};
            rem_r      <= {DATA_W{1'b0}};
            quot_r     <= {DATA_W{1'b0}};
            divisor_r  <= {DATA_W{1'b0}};
            dividend_r <= {DATA_W{1'b0}};
            dz_r       <= 1'b0;
`ifdef KERNEL_NIOS2_DIV_SIGNED_EN
            qneg_r     <= 1'b0;
            rneg_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        quot_r     <= src1_mag_s;
                        rem_r      <= {DATA_W{1'b0}};
                        divisor_r  <= src2_mag_s;
                        dividend_r <= bus.A_div_src1;
                        dz_r       <= (bus.A_div_src2 == {DATA_W{1'b0}});
                        count_r    <= CNT_W'(DATA_W - 1);
`ifdef KERNEL_NIOS2_DIV_SIGNED_EN
                        qneg_r     <= bus.A_div_signed & (bus.A_div_src1[DATA_W-1] ^ bus.A_div_src2[DATA_W-1]);
                        rneg_r     <= bus.A_div_signed & bus.A_div_src1[DATA_W-1];
`endif
                    end
                end
                CALC: begin
                    rem_r  <= rem_step_s;
                    quot_r <= quot_step_s;
                    if (count_r != {CNT_W{1'b0}}) begin
                        count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            quot_out_r <= {DATA_W{1'b0}};
            rem_out_r  <= {DATA_W{1'b0}};
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_r == FIX);
            if (state_r == FIX) begin
                quot_out_r <= quot_fix_s;
                rem_out_r  <= rem_fix_s;
            end
        end
    end

    assign bus.A_div_busy = busy_r;
    assign bus.A_div_done = done_r;
    assign bus.A_div_quot = quot_out_r;
    assign bus.A_div_rem  = rem_out_r;

endmodule

// File: tb/tb_kernel_nios2_div_cell.sv
// Directed bench for kernel_nios2_div_cell: vector table plus start-overlap and reset sequences.
module tb_kernel_nios2_div_cell;
    import kernel_nios2_div_pkg::*;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic        sg;
        logic [31:0] q;
        logic [31:0] r;
        string       name;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    vec_t vecs [11];

    kernel_nios2_div_cell_if #(.DATA_W(32)) bus ();

    kernel_nios2_div_cell dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [31:0] s1, input logic [31:0] s2, input logic sg);
        bus.A_div_start  = 1'b1;
        bus.A_div_src1   = s1;
        bus.A_div_src2   = s2;
        bus.A_div_signed = sg;
    endtask

    // Called in cycle 0 (start already driven); samples #1 after each rising edge.
    task automatic track(input logic [31:0] eq, input logic [31:0] er, input string name,
                         input int repulse_at, input bit chain,
                         input logic [31:0] cs1, input logic [31:0] cs2);
        int          done_cyc;
        int          done_cnt;
        int          busy_bad;
        int          last;
        logic [31:0] q_s;
        logic [31:0] r_s;
        done_cyc = 0;
        done_cnt = 0;
        busy_bad = 0;
        q_s      = 32'd0;
        r_s      = 32'd0;
        last     = chain ? DIV_LATENCY : DIV_LATENCY + 4;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.A_div_start = 1'b0;
            if (c == repulse_at) launch(32'd50, 32'd3, 1'b0);
            if (c == repulse_at + 1) bus.A_div_start = 1'b0;
            if (bus.A_div_busy !== ((c >= 1) && (c <= DIV_LATENCY - 1))) busy_bad++;
            if (bus.A_div_done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    q_s      = bus.A_div_quot;
                    r_s      = bus.A_div_rem;
                end
            end
            if (chain && (c == DIV_LATENCY)) launch(cs1, cs2, 1'b0);
        end
        chk({name, "_quot"},     q_s, eq);
        chk({name, "_rem"},      r_s, er);
        chk({name, "_done_cyc"}, 32'(done_cyc), 32'(DIV_LATENCY));
        chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({name, "_busy_bad"}, 32'(busy_bad), 32'd0);
        if (!chain) begin
            chk({name, "_quot_hold"}, bus.A_div_quot, eq);
            chk({name, "_rem_hold"},  bus.A_div_rem,  er);
        end
    endtask

    initial begin
        int dn;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.A_div_start  = 1'b0;
        bus.A_div_src1   = 32'd0;
        bus.A_div_src2   = 32'd0;
        bus.A_div_signed = 1'b0;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          "u100_7"};
        vecs[1]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          "u5_0"};
        vecs[2]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          "umax_1"};
        vecs[3]  = '{32'd3,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd3,          "u3_max"};
        vecs[4]  = '{32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 32'd1,          32'h7FFF_FFFE,  "u_bigdiv"};
        vecs[5]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          "u_m7_2"};
        vecs[6]  = '{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          "s5_0"};
`ifdef KERNEL_NIOS2_DIV_SIGNED_EN
        vecs[7]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  "s_m7_2"};
        vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          "s_ovf"};
        vecs[9]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          "s_7_m2"};
        vecs[10] = '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  "s_m100_7"};
`else
        vecs[7]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1,          "s_m7_2"};
        vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  "s_ovf"};
        vecs[9]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'd0,          32'd7,          "s_7_m2"};
        vecs[10] = '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'h2492_4916,  32'd2,          "s_m100_7"};
`endif

        #2;
        chk("rst_busy", {31'd0, bus.A_div_busy}, 32'd0);
        chk("rst_done", {31'd0, bus.A_div_done}, 32'd0);
        chk("rst_quot", bus.A_div_quot, 32'd0);
        chk("rst_rem",  bus.A_div_rem,  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            launch(vecs[i].s1, vecs[i].s2, vecs[i].sg);
            track(vecs[i].q, vecs[i].r, vecs[i].name, 0, 1'b0, 32'd0, 32'd0);
        end

        // Start re-pulsed while busy is ignored; start in the done cycle is accepted.
        @(posedge clk);
        #1;
        launch(32'd100, 32'd7, 1'b0);
        track(32'd14, 32'd2, "repulse", 10, 1'b1, 32'd9, 32'd4);
        track(32'd2, 32'd1, "chain", 0, 1'b0, 32'd0, 32'd0);

        // Reset mid-operation: outputs clear at once and the operation never completes.
        @(posedge clk);
        #1;
        launch(32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.A_div_start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus.A_div_busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.A_div_done}, 32'd0);
        chk("midrst_quot", bus.A_div_quot, 32'd0);
        chk("midrst_rem",  bus.A_div_rem,  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ((bus.A_div_done !== 1'b0) || (bus.A_div_busy !== 1'b0)) dn++;
        end
        chk("midrst_no_done", 32'(dn), 32'd0);
        @(posedge clk);
        #1;
        launch(32'd9, 32'd4, 1'b0);
        track(32'd2, 32'd1, "after_rst", 0, 1'b0, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
